// File: rtl/spi_reg_bridge.sv
// SPI byte stream to register-bus bridge.
// A command byte {rw, addr} opens a frame. Writes stream data to addr, addr+1, ...
// Reads use a prefetch register so that each returned byte is ready one fclk
// after the previous byte completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a command byte; MISO carries STATUS
// WR       | write burst; each byte becomes one bus write, addr auto-increments
// RD_DUMMY | first read prefetch outstanding; MISO carries STATUS
// RD       | read burst; each byte loads MISO from prefetch and issues next read
module spi_reg_bridge #(
   parameter int unsigned         IODepth  = 8,
   parameter int unsigned         AW       = 7,
   parameter int unsigned         TIMEOUT  = 255,
   parameter logic [IODepth-1:0]  ERR_BYTE = 8'hEE
) (
   input  logic               fclk,
   input  logic               rst_n,
   input  logic               spi_cs,
   input  logic               spi_rdy,
   input  logic [IODepth-1:0] spi_dat_i,
   output logic [IODepth-1:0] spi_dat_o,
   output logic               bus_req,
   output logic               bus_we,
   output logic [AW-1:0]      bus_addr,
   output logic [IODepth-1:0] bus_wdata,
   input  logic               bus_ack,
   input  logic [IODepth-1:0] bus_rdata,
   output logic               busy,
   output logic               err_flag
);

   localparam int unsigned        TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]      TMR_LOAD = TW'(TIMEOUT - 1);
   localparam logic [IODepth-3:0] STAT_ID  = (IODepth-2)'(6'h25);

   typedef enum logic [1:0] {IDLE, WR, RD_DUMMY, RD} state_t;

   state_t               state_q, state_d;
   logic                 rdy_q;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 req_q, req_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        baddr_q, baddr_d;
   logic [IODepth-1:0]   wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [IODepth-1:0]   pref_q, pref_d;
   logic [IODepth-1:0]   dout_q, dout_d;
   logic [TW-1:0]        tmr_q, tmr_d;

   logic                 byte_stb;
   logic                 rd_state;
   logic                 iss;
   logic                 iss_we;
   logic [AW-1:0]        iss_addr;
   logic [IODepth-1:0]   iss_wdata;
   logic [AW-1:0]        addr_inc;

   assign byte_stb = spi_rdy & ~rdy_q & spi_cs;
   assign rd_state = (state_q == RD_DUMMY) || (state_q == RD);
   assign addr_inc = addr_q + AW'(1);

   // Next-state: bus handshake/timeout first, then byte handling, then issue.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      req_d     = req_q;
      we_d      = we_q;
      baddr_d   = baddr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      pref_d    = pref_q;
      dout_d    = dout_q;
      tmr_d     = tmr_q;
      iss       = 1'b0;
      iss_we    = 1'b0;
      iss_addr  = addr_q;
      iss_wdata = wdata_q;

      if (req_q) begin
         if (bus_ack) begin
            req_d = 1'b0;
            // read data of a transaction orphaned by frame end is dropped
            if (!we_q && rd_state) pref_d = bus_rdata;
         end else if (tmr_q == '0) begin
            req_d  = 1'b0;
            err_d  = 1'b1;
            pref_d = ERR_BYTE;
         end else begin
            tmr_d = tmr_q - TW'(1);
         end
      end

      if (!spi_cs) begin
         state_d = IDLE;
      end else if (byte_stb) begin
         unique case (state_q)
            IDLE: begin
               if (req_q) begin
                  err_d = 1'b1;
               end else begin
                  err_d  = 1'b0;
                  addr_d = spi_dat_i[AW-1:0];
                  if (spi_dat_i[IODepth-1]) begin
                     state_d = WR;
                  end else begin
                     iss      = 1'b1;
                     iss_addr = spi_dat_i[AW-1:0];
                     state_d  = RD_DUMMY;
                  end
               end
            end
            WR: begin
               if (req_q) begin
                  err_d = 1'b1;
               end else begin
                  iss       = 1'b1;
                  iss_we    = 1'b1;
                  iss_addr  = addr_q;
                  iss_wdata = spi_dat_i;
                  addr_d    = addr_inc;
               end
            end
            RD_DUMMY, RD: begin
               addr_d  = addr_inc;
               state_d = RD;
               if (!req_q) begin
                  dout_d   = pref_q;
                  iss      = 1'b1;
                  iss_addr = addr_inc;
               end else if (bus_ack) begin
                  // ack lands with the strobe: forward its data straight to MISO
                  dout_d   = bus_rdata;
                  iss      = 1'b1;
                  iss_addr = addr_inc;
               end else begin
                  err_d  = 1'b1;
                  dout_d = ERR_BYTE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (iss) begin
         req_d   = 1'b1;
         we_d    = iss_we;
         baddr_d = iss_addr;
         wdata_d = iss_wdata;
         tmr_d   = TMR_LOAD;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         addr_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         baddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         pref_q  <= '0;
         dout_q  <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= spi_rdy;
         addr_q  <= addr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         baddr_q <= baddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         pref_q  <= pref_d;
         dout_q  <= dout_d;
         tmr_q   <= tmr_d;
      end
   end

   assign bus_req   = req_q;
   assign busy      = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = baddr_q;
   assign bus_wdata = wdata_q;
   assign err_flag  = err_q;
   assign spi_dat_o = (state_q == RD) ? dout_q : {err_q, req_q, STAT_ID};

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI byte source, bus responder, checks.
module tb_spi_reg_bridge;

   localparam int BYTE_CYC = 64;

   logic       fclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_cs = 1'b0;
   logic       spi_rdy = 1'b0;
   logic [7:0] spi_dat_i = 8'h00;
   logic [7:0] spi_dat_o;
   logic       bus_req;
   logic       bus_we;
   logic [6:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_ack = 1'b0;
   logic [7:0] bus_rdata = 8'h00;
   logic       busy;
   logic       err_flag;

   int n_cmp = 0;
   int n_err = 0;

   int ack_dly = -1;
   int n_req = 0;
   int last_len = 0;
   logic [6:0] st_addr[$];
   logic       st_we[$];
   logic [7:0] st_wdata[$];
   logic [7:0] miso;

   spi_reg_bridge dut (
      .fclk      (fclk),
      .rst_n     (rst_n),
      .spi_cs    (spi_cs),
      .spi_rdy   (spi_rdy),
      .spi_dat_i (spi_dat_i),
      .spi_dat_o (spi_dat_o),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .busy      (busy),
      .err_flag  (err_flag)
   );

   always #5 fclk = ~fclk;

   // Bus responder: logs each transaction start, acks after ack_dly cycles
   // (never if negative) with data A0+addr, and records req high-run length.
   initial begin
      int cnt;
      int run;
      cnt = 0;
      run = 0;
      forever begin
         @(posedge fclk);
         #1;
         if (bus_ack) begin
            bus_ack = 1'b0;
            cnt = 0;
         end
         if (bus_req) begin
            if (cnt == 0) begin
               n_req++;
               st_addr.push_back(bus_addr);
               st_we.push_back(bus_we);
               st_wdata.push_back(bus_wdata);
            end
            if (cnt == ack_dly) begin
               bus_ack = 1'b1;
               bus_rdata = 8'hA0 + {1'b0, bus_addr};
            end
            cnt++;
            run++;
         end else begin
            cnt = 0;
            if (run != 0) last_len = run;
            run = 0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, observed time %0t expected < 2ms", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One SPI byte: MISO is sampled just before the slave raises rdy.
   task automatic xfer(input logic [7:0] mosi, output logic [7:0] so);
      repeat (BYTE_CYC - 3) @(posedge fclk);
      #1;
      so = spi_dat_o;
      spi_dat_i = mosi;
      spi_rdy = 1'b1;
      repeat (2) @(posedge fclk);
      #1 spi_rdy = 1'b0;
   endtask

   task automatic wait_req_low(input string tag, input int lim);
      int i;
      i = 0;
      while (bus_req === 1'b1 && i < lim) begin
         @(posedge fclk);
         #1;
         i++;
      end
      chk(tag, bus_req, 1'b0);
      repeat (2) @(posedge fclk);
      #1;
   endtask

   task automatic clear_log();
      n_req = 0;
      st_addr.delete();
      st_we.delete();
      st_wdata.delete();
   endtask

   initial begin
      // reset
      repeat (3) @(posedge fclk);
      #1 rst_n = 1'b1;
      @(posedge fclk);
      #1;
      chk("rst_dat_o", spi_dat_o, 8'h25);
      chk("rst_req", bus_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_flag, 1'b0);
      chk("rst_we", bus_we, 1'b0);
      chk("rst_addr", bus_addr, 7'h00);
      chk("rst_wdata", bus_wdata, 8'h00);

      // 1: write burst 11@05, 22@06
      ack_dly = 2;
      spi_cs = 1'b1;
      xfer(8'h85, miso);
      chk("t1_miso0", miso, 8'h25);
      xfer(8'h11, miso);
      xfer(8'h22, miso);
      chk("t1_req_hold", bus_req, 1'b1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_we_hold", bus_we, 1'b1);
      chk("t1_addr_hold", bus_addr, 7'h06);
      chk("t1_wdata_hold", bus_wdata, 8'h22);
      wait_req_low("t1_req_low", 20);
      spi_cs = 1'b0;
      repeat (2) @(posedge fclk);
      #1;
      chk("t1_err", err_flag, 1'b0);
      chk("t1_dat_o_end", spi_dat_o, 8'h25);
      chk("t1_nreq", n_req, 2);
      chk("t1_addr0", st_addr[0], 7'h05);
      chk("t1_wdata0", st_wdata[0], 8'h11);
      chk("t1_addr1", st_addr[1], 7'h06);
      chk("t1_wdata1", st_wdata[1], 8'h22);

      // 2: read burst from 10
      clear_log();
      spi_cs = 1'b1;
      xfer(8'h10, miso);
      chk("t2_miso0", miso, 8'h25);
      xfer(8'h00, miso);
      chk("t2_miso1", miso, 8'h25);
      xfer(8'h00, miso);
      chk("t2_miso2", miso, 8'hB0);
      repeat (BYTE_CYC - 3) @(posedge fclk);
      #1;
      chk("t2_miso3", spi_dat_o, 8'hB1);
      spi_cs = 1'b0;
      wait_req_low("t2_req_low", 20);
      chk("t2_dat_o_end", spi_dat_o, 8'h25);
      chk("t2_nreq", n_req, 3);
      chk("t2_addr0", st_addr[0], 7'h10);
      chk("t2_addr2", st_addr[2], 7'h12);
      chk("t2_we2", st_we[2], 1'b0);

      // 3: write burst wrapping 7E, 7F, 00
      clear_log();
      spi_cs = 1'b1;
      xfer(8'hFE, miso);
      xfer(8'h01, miso);
      xfer(8'h02, miso);
      xfer(8'h03, miso);
      wait_req_low("t3_req_low", 20);
      spi_cs = 1'b0;
      chk("t3_nreq", n_req, 3);
      chk("t3_addr0", st_addr[0], 7'h7E);
      chk("t3_addr1", st_addr[1], 7'h7F);
      chk("t3_addr2", st_addr[2], 7'h00);
      chk("t3_wdata2", st_wdata[2], 8'h03);

      // 4: read of 03 with no ack -> timeout
      clear_log();
      ack_dly = -1;
      @(posedge fclk);
      #1 spi_cs = 1'b1;
      xfer(8'h03, miso);
      chk("t4_miso0", miso, 8'h25);
      xfer(8'h00, miso);
      chk("t4_miso1", miso, 8'h65);
      chk("t4_err_overrun", err_flag, 1'b1);
      xfer(8'h00, miso);
      chk("t4_miso2", miso, 8'hEE);
      wait_req_low("t4_req_drop", 300);
      chk("t4_req_len", last_len, 255);
      chk("t4_err", err_flag, 1'b1);
      chk("t4_nreq", n_req, 1);
      spi_cs = 1'b0;
      repeat (2) @(posedge fclk);
      #1 spi_cs = 1'b1;
      xfer(8'h81, miso);
      chk("t4_next_miso0", miso, 8'hA5);
      chk("t4_err_cleared", err_flag, 1'b0);
      spi_cs = 1'b0;

      // 5: second write while first unacked -> dropped
      clear_log();
      ack_dly = 300;
      @(posedge fclk);
      #1 spi_cs = 1'b1;
      xfer(8'hA0, miso);
      xfer(8'hAA, miso);
      xfer(8'hBB, miso);
      chk("t5_err", err_flag, 1'b1);
      wait_req_low("t5_req_drop", 300);
      chk("t5_nreq", n_req, 1);
      chk("t5_we0", st_we[0], 1'b1);
      chk("t5_addr0", st_addr[0], 7'h20);
      chk("t5_wdata0", st_wdata[0], 8'hAA);
      chk("t5_req_len", last_len, 255);
      spi_cs = 1'b0;

      // 6: cs drops mid read, ack arrives later
      clear_log();
      ack_dly = 6;
      repeat (2) @(posedge fclk);
      #1 spi_cs = 1'b1;
      xfer(8'h40, miso);
      spi_cs = 1'b0;
      repeat (2) @(posedge fclk);
      #1;
      chk("t6_req_held", bus_req, 1'b1);
      chk("t6_dat_o_busy", spi_dat_o, 8'h65);
      wait_req_low("t6_req_low", 20);
      chk("t6_req_len", last_len, 7);
      chk("t6_dat_o_end", spi_dat_o, 8'h25);
      repeat (100) @(posedge fclk);
      #1;
      chk("t6_nreq", n_req, 1);
      chk("t6_req_idle", bus_req, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
